online_div_sequencer: RTL and testbench

Top-level sequencer for the online divider. It generates the `cnt_master` timebase that drives the computation controller and the CA_RAM datapath: four phase slots per digit cycle, with the digit cycle number in `cnt_master[8:2]`. It accepts one input digit per digit cycle through a valid/ready handshake and signals when the datapath's result digit for that cycle is valid, after the online delay. It also frames each division with a start/busy/done protocol.

---
 rtl/online_div_sequencer_pkg.sv | 21 ++
 rtl/online_div_sequencer_if.sv | 48 ++++
 rtl/online_div_sequencer.sv | 143 ++++++++++++++
 tb/tb_online_div_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/online_div_sequencer_pkg.sv
// Shared definitions for the online divider sequencer: FSM state encoding,
// phase-slot names and timebase field widths.
package online_div_pkg;

    // Width of the phase/cycle timebase and of its digit-cycle field
    localparam int CNT_W   = 9;
    localparam int CYCLE_W = 7;

    // Phase slot in which an operand digit is fetched
    localparam logic [1:0] PHASE_FETCH = 2'b00;
    // Phase slot in which a result digit is emitted
    localparam logic [1:0] PHASE_EMIT  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/online_div_sequencer_if.sv
// Handshake and timebase bundle between the online divider sequencer and its
// surroundings (operand source, result sink, computation controller).
interface online_div_sequencer_if;
    import online_div_pkg::*;

    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic                 zero_digit;
    logic [CNT_W-1:0]     cnt_master;
    logic                 out_valid;
    logic                 out_ready;
    logic [CYCLE_W-1:0]   out_index;
    logic                 busy;
    logic                 done;

    // The side that requests divisions and moves digits in and out
    modport master (
        output start,
        output abort,
        output in_valid,
        input  in_ready,
        input  zero_digit,
        input  cnt_master,
        input  out_valid,
        output out_ready,
        input  out_index,
        input  busy,
        input  done
    );

    // The sequencer itself
    modport slave (
        input  start,
        input  abort,
        input  in_valid,
        output in_ready,
        output zero_digit,
        output cnt_master,
        output out_valid,
        input  out_ready,
        output out_index,
        output busy,
        output done
    );

endinterface

// File: rtl/online_div_sequencer.sv
// Online divider sequencer: generates the four-phase digit-cycle timebase,
// paces operand digits in and result digits out with valid/ready handshakes,
// and frames each division with start/busy/done.
module online_div_sequencer
    import online_div_pkg::*;
#(
    parameter int DIGITS = 32,
    parameter int DELTA  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    online_div_sequencer_if.slave  bus
);

    // Digit cycle index must fit the 7-bit cycle field
    if ((DIGITS < 1) || (DELTA < 0) || (DIGITS + DELTA > 128)) begin : g_bad_params
        $error("online_div_sequencer: DIGITS+DELTA must be within 1..128 and DIGITS >= 1");
    end

    // Comparisons are done one bit wider than the cycle field so that the
    // bounds never wrap, even at the edge of the legal range.
    localparam int LAST = DIGITS + DELTA - 1;
    localparam logic [CYCLE_W:0]   DIGITS_W = (CYCLE_W+1)'(DIGITS);
    localparam logic [CYCLE_W:0]   DELTA_W  = (CYCLE_W+1)'(DELTA);
    localparam logic [CYCLE_W:0]   LAST_W   = (CYCLE_W+1)'(LAST);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_W-1:0] IDX_ZERO = {CYCLE_W{1'b0}};

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_FIN  = ST_FIN;

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;

    logic [1:0]         phase_s;
    logic [CYCLE_W:0]   cycle_s;
    logic               run_s;
    logic               fetch_s;
    logic               zero_s;
    logic               emit_s;
    logic               last_s;
    logic               stall_s;
    logic [CYCLE_W-1:0] out_index_s;

    assign phase_s = cnt_r[1:0];
    assign cycle_s = {1'b0, cnt_r[CNT_W-1:2]};
    assign run_s   = (state_r == S_RUN);

    // Decode the per-slot strobes from the registered state and timebase
    always_comb begin
        fetch_s     = 1'b0;
        zero_s      = 1'b0;
        emit_s      = 1'b0;
        last_s      = (cycle_s == LAST_W);
        out_index_s = IDX_ZERO;
        if (run_s && (phase_s == PHASE_FETCH)) begin
            if (cycle_s < DIGITS_W) begin
                fetch_s = 1'b1;
            end else begin
                zero_s  = 1'b1;
            end
        end else begin
            fetch_s = 1'b0;
            zero_s  = 1'b0;
        end
        if (run_s && (phase_s == PHASE_EMIT) && (cycle_s >= DELTA_W)) begin
            emit_s      = 1'b1;
            out_index_s = CYCLE_W'(cycle_s - DELTA_W);
        end else begin
            emit_s      = 1'b0;
            out_index_s = IDX_ZERO;
        end
    end

    // The timebase freezes while an operand or result handshake is pending
    assign stall_s = (fetch_s && !bus.in_valid) || (emit_s && !bus.out_ready);

    // Next state and next timebase value
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (bus.abort) begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_nxt_s = CNT_ZERO;
                    if (bus.start) begin
                        state_nxt_s = S_RUN;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (stall_s) begin
                        state_nxt_s = S_RUN;
                        cnt_nxt_s   = cnt_r;
                    end else if ((phase_s == PHASE_EMIT) && last_s) begin
                        // Final result digit accepted; timebase stays put
                        state_nxt_s = S_FIN;
                        cnt_nxt_s   = cnt_r;
                    end else begin
                        state_nxt_s = S_RUN;
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                S_FIN: begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and timebase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign bus.cnt_master = cnt_r;
    assign bus.in_ready   = fetch_s;
    assign bus.zero_digit = zero_s;
    assign bus.out_valid  = emit_s;
    assign bus.out_index  = out_index_s;
    assign bus.busy       = (state_r != S_IDLE);
    assign bus.done       = (state_r == S_FIN);

endmodule

// File: tb/tb_online_div_sequencer.sv
// Directed bench for online_div_sequencer with DIGITS=4, DELTA=3: a vector
// table for the unstalled run plus hand-written stall/abort/reset sequences.
module tb_online_div_sequencer;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    online_div_sequencer_if bus_if ();

    online_div_sequencer #(
        .DIGITS (4),
        .DELTA  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int k;      // cycles since the start edge
        int cnt;
        int ir;
        int zd;
        int ov;
        int idx;
        int busy;
        int done;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(output int k);
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        k = 1;
    endtask

    task automatic run_to_cnt(input int target, inout int k);
        int guard;
        guard = 0;
        while ((int'(bus_if.cnt_master) != target) && (guard < 200)) begin
            step();
            k++;
            guard++;
        end
        chk("reach_cnt", int'(bus_if.cnt_master), target);
    endtask

    task automatic wait_done(inout int k);
        int guard;
        guard = 0;
        while ((bus_if.done !== 1'b1) && (guard < 300)) begin
            step();
            k++;
            guard++;
        end
        chk("done_seen", int'(bus_if.done), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},  int'(bus_if.cnt_master), 0);
        chk({tag, "_busy"}, int'(bus_if.busy), 0);
        chk({tag, "_done"}, int'(bus_if.done), 0);
        chk({tag, "_ir"},   int'(bus_if.in_ready), 0);
        chk({tag, "_ov"},   int'(bus_if.out_valid), 0);
        chk({tag, "_zd"},   int'(bus_if.zero_digit), 0);
        chk({tag, "_idx"},  int'(bus_if.out_index), 0);
    endtask

    initial begin
        int k;
        int n_ir;
        int n_zd;
        int n_ov;
        passed = 0;
        total  = 0;

        //           k  cnt ir zd ov idx busy done
        vecs[0]  = '{ 1,  0, 1, 0, 0, 0, 1, 0};
        vecs[1]  = '{ 2,  1, 0, 0, 0, 0, 1, 0};
        vecs[2]  = '{ 5,  4, 1, 0, 0, 0, 1, 0};
        vecs[3]  = '{ 9,  8, 1, 0, 0, 0, 1, 0};
        vecs[4]  = '{13, 12, 1, 0, 0, 0, 1, 0};
        vecs[5]  = '{14, 13, 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{16, 15, 0, 0, 1, 0, 1, 0};
        vecs[7]  = '{17, 16, 0, 1, 0, 0, 1, 0};
        vecs[8]  = '{20, 19, 0, 0, 1, 1, 1, 0};
        vecs[9]  = '{21, 20, 0, 1, 0, 0, 1, 0};
        vecs[10] = '{24, 23, 0, 0, 1, 2, 1, 0};
        vecs[11] = '{25, 24, 0, 1, 0, 0, 1, 0};
        vecs[12] = '{28, 27, 0, 0, 1, 3, 1, 0};
        vecs[13] = '{29, 27, 0, 0, 0, 0, 1, 1};
        vecs[14] = '{30,  0, 0, 0, 0, 0, 0, 0};

        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.abort     = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk_all_zero("idle");

        // Unstalled run, table driven
        n_ir = 0;
        n_zd = 0;
        n_ov = 0;
        do_start(k);
        for (int c = 1; c <= 30; c++) begin
            if (c <= 28) begin
                chk($sformatf("nom_cnt_k%0d", c), int'(bus_if.cnt_master), c - 1);
            end
            n_ir += int'(bus_if.in_ready);
            n_zd += int'(bus_if.zero_digit);
            n_ov += int'(bus_if.out_valid);
            for (int v = 0; v < 15; v++) begin
                if (vecs[v].k == c) begin
                    chk($sformatf("vec%0d_cnt", v),  int'(bus_if.cnt_master), vecs[v].cnt);
                    chk($sformatf("vec%0d_ir", v),   int'(bus_if.in_ready),   vecs[v].ir);
                    chk($sformatf("vec%0d_zd", v),   int'(bus_if.zero_digit), vecs[v].zd);
                    chk($sformatf("vec%0d_ov", v),   int'(bus_if.out_valid),  vecs[v].ov);
                    chk($sformatf("vec%0d_idx", v),  int'(bus_if.out_index),  vecs[v].idx);
                    chk($sformatf("vec%0d_busy", v), int'(bus_if.busy),       vecs[v].busy);
                    chk($sformatf("vec%0d_done", v), int'(bus_if.done),       vecs[v].done);
                end
            end
            step();
        end
        chk("nom_n_in_ready", n_ir, 4);
        chk("nom_n_zero", n_zd, 3);
        chk("nom_n_out_valid", n_ov, 4);

        // Input stall: in_valid low for 5 cycles at cnt 8
        do_start(k);
        run_to_cnt(8, k);
        chk("ivs_k_at_8", k, 9);
        bus_if.in_valid = 1'b0;
        repeat (5) begin
            step();
            k++;
            chk("ivs_hold_cnt", int'(bus_if.cnt_master), 8);
            chk("ivs_hold_ir", int'(bus_if.in_ready), 1);
        end
        bus_if.in_valid = 1'b1;
        step();
        k++;
        chk("ivs_resume_cnt", int'(bus_if.cnt_master), 9);
        wait_done(k);
        chk("ivs_done_k", k, 34);
        step();

        // Output stall: out_ready low for 3 cycles at cnt 19
        do_start(k);
        run_to_cnt(19, k);
        bus_if.out_ready = 1'b0;
        repeat (3) begin
            step();
            k++;
            chk("ovs_hold_cnt", int'(bus_if.cnt_master), 19);
            chk("ovs_hold_ov", int'(bus_if.out_valid), 1);
            chk("ovs_hold_idx", int'(bus_if.out_index), 1);
        end
        bus_if.out_ready = 1'b1;
        step();
        k++;
        chk("ovs_resume_cnt", int'(bus_if.cnt_master), 20);
        wait_done(k);
        chk("ovs_done_k", k, 32);
        step();

        // Abort mid-run, then a fresh run
        do_start(k);
        run_to_cnt(10, k);
        bus_if.abort = 1'b1;
        bus_if.start = 1'b1;
        step();
        bus_if.abort = 1'b0;
        bus_if.start = 1'b0;
        chk("abort_cnt", int'(bus_if.cnt_master), 0);
        chk("abort_busy", int'(bus_if.busy), 0);
        chk("abort_done", int'(bus_if.done), 0);
        repeat (3) begin
            step();
            chk("abort_idle_busy", int'(bus_if.busy), 0);
            chk("abort_idle_done", int'(bus_if.done), 0);
        end
        do_start(k);
        wait_done(k);
        chk("post_abort_done_k", k, 29);
        step();

        // start pulsed in RUN and in FIN, then back-to-back start
        do_start(k);
        run_to_cnt(5, k);
        bus_if.start = 1'b1;
        step();
        k++;
        bus_if.start = 1'b0;
        chk("run_start_ignored_cnt", int'(bus_if.cnt_master), 6);
        wait_done(k);
        chk("ign_done_k", k, 29);
        bus_if.start = 1'b1;
        step();
        chk("fin_start_ignored_busy", int'(bus_if.busy), 0);
        chk("fin_start_ignored_cnt", int'(bus_if.cnt_master), 0);
        chk("fin_start_ignored_done", int'(bus_if.done), 0);
        step();
        bus_if.start = 1'b0;
        k = 1;
        chk("b2b_busy", int'(bus_if.busy), 1);
        chk("b2b_cnt", int'(bus_if.cnt_master), 0);
        chk("b2b_ir", int'(bus_if.in_ready), 1);
        wait_done(k);
        chk("b2b_done_k", k, 29);
        step();

        // Asynchronous reset at cnt 13, checked before the next clock edge
        do_start(k);
        run_to_cnt(13, k);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", int'(bus_if.busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
